// File: rtl/seq_match_ctrl_if.sv
// Control/status and serial-input bundle for seq_match_ctrl.
// master drives run requests and bits; slave is the controller.
interface seq_match_ctrl_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int TMO_W = 16
) ();
   logic             start;
   logic             abort;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] target;
   logic [TMO_W-1:0] timeout;
   logic             in_valid;
   logic             in;
   logic             busy;
   logic             hit;
   logic             done;
   logic             timed_out;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output start, abort, pattern, target, timeout, in_valid, in,
      input  busy, hit, done, timed_out, match_cnt
   );

   modport slave (
      input  start, abort, pattern, target, timeout, in_valid, in,
      output busy, hit, done, timed_out, match_cnt
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run controller for an overlapping serial pattern matcher with match target and abort.
// Define SEQ_MATCH_CTRL_TIMEOUT_EN to build the SEARCH cycle-budget timeout and TMO state.
module seq_match_ctrl #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int TMO_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   seq_match_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SEARCH, DONE, TMO} state_t;

   localparam int            BW        = $clog2(PAT_W + 1);
   localparam logic [BW-1:0] BITS_FULL = BW'(PAT_W);

   state_t           state, state_nxt;
   logic [PAT_W-1:0] sh, sh_nxt, pat_lat;
   logic [BW-1:0]    bits, bits_nxt;
   logic [CNT_W-1:0] tgt_lat, cnt;
   logic             hit_q;
   logic             accept, shift_en, match, reached, tmo_hit;

   // abort overrides both a new start and a match completing in the same cycle
   assign accept   = bus.start && !bus.abort && (state != SEARCH);
   assign shift_en = (state == SEARCH) && bus.in_valid && !bus.abort;
   assign sh_nxt   = {sh[PAT_W-2:0], bus.in};
   assign bits_nxt = (bits == BITS_FULL) ? bits : bits + BW'(1);
   assign match    = shift_en && (sh_nxt == pat_lat) && (bits_nxt == BITS_FULL);
   assign reached  = ({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, tgt_lat};

`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_lat, tmo_cnt;
   assign tmo_hit = (tmo_lat != '0) && (tmo_cnt == tmo_lat);
`else
   assign tmo_hit = 1'b0;
`endif

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            SEARCH: begin
               if (match && reached) state_nxt = DONE;
               else if (tmo_hit)     state_nxt = TMO;
            end
            default: begin
               if (bus.start) state_nxt = (bus.target == '0) ? DONE : SEARCH;
            end
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state == SEARCH);
      bus.done      = (state == DONE);
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      bus.timed_out = (state == TMO);
`else
      bus.timed_out = 1'b0;
`endif
      bus.hit       = hit_q;
      bus.match_cnt = cnt;
   end

   // NOTE: latched configuration is reset too, so nothing powers up unknown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh      <= '0;
         bits    <= '0;
         pat_lat <= '0;
         tgt_lat <= '0;
         cnt     <= '0;
         hit_q   <= 1'b0;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
         tmo_lat <= '0;
         tmo_cnt <= '0;
`endif
      end else begin
         hit_q <= match;
         if (accept) begin
            pat_lat <= bus.pattern;
            tgt_lat <= bus.target;
            cnt     <= '0;
            sh      <= '0;
            bits    <= '0;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
            tmo_lat <= bus.timeout;
            tmo_cnt <= '0;
`endif
         end else begin
            if (shift_en) begin
               sh   <= sh_nxt;
               bits <= bits_nxt;
            end
            if (match && (cnt != '1)) cnt <= cnt + CNT_W'(1);
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
            if (state == SEARCH) tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
         end
      end
   end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: stimulus queues expected hits, a monitor checks them.
module tb_seq_match_ctrl;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int TMO_W = 16;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t exp_q[$];

   seq_match_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

   seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // Monitor: every hit pops one expected entry.
   always @(negedge clk) begin
      if (rst_n && bus.hit) begin
         if (exp_q.size() == 0) begin
            check("stray_hit", 32'(bus.hit), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("hit_cnt", 32'(bus.match_cnt), 32'(e.cnt));
            check("hit_done", 32'(bus.done), 32'(e.done));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cycle(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_run(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t,
                            input logic [TMO_W-1:0] tmo);
      bus.pattern  = p;
      bus.target   = t;
      bus.timeout  = tmo;
      bus.in_valid = 1'b0;
      bus.start    = 1'b1;
      cycle();
      bus.start    = 1'b0;
   endtask

   task automatic send(input logic b, input logic v, input logic exp_hit,
                       input logic [CNT_W-1:0] ecnt, input logic edone);
      bus.in       = b;
      bus.in_valid = v;
      if (exp_hit) exp_q.push_back('{cnt: ecnt, done: edone});
      cycle();
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      cycle(n);
   endtask

   task automatic check_out(input string tag, input logic eb, input logic ed,
                            input logic et, input logic [CNT_W-1:0] ec);
      check({tag, "_busy"}, 32'(bus.busy), 32'(eb));
      check({tag, "_done"}, 32'(bus.done), 32'(ed));
      check({tag, "_tmo"}, 32'(bus.timed_out), 32'(et));
      check({tag, "_cnt"}, 32'(bus.match_cnt), 32'(ec));
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0; bus.target = '0;
      bus.timeout = '0; bus.in_valid = 1'b0; bus.in = 1'b0;

      // Reset
      cycle(2);
      check_out("rst", 1'b0, 1'b0, 1'b0, 8'd0);
      check("rst_hit", 32'(bus.hit), 32'd0);
      rst_n = 1'b1;
      cycle();
      check_out("idle", 1'b0, 1'b0, 1'b0, 8'd0);

      // Overlapping matches, target 2
      start_run(4'b1011, 8'd2, 16'd0);
      check("t1_busy", 32'(bus.busy), 32'd1);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      send(1, 1, 1, 8'd1, 0);
      send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      send(1, 1, 1, 8'd2, 1);
      check_out("t1_end", 1'b0, 1'b1, 1'b0, 8'd2);
      idle(3);
      check_out("t1_hold", 1'b0, 1'b1, 1'b0, 8'd2);

      // Timeout 5 with zero stream
      start_run(4'b1011, 8'd3, 16'd5);
      check_out("t2_start", 1'b1, 1'b0, 1'b0, 8'd0);
      bus.in = 1'b0; bus.in_valid = 1'b1;
      cycle(5);
      check_out("t2_pre", 1'b1, 1'b0, 1'b0, 8'd0);
      cycle();
      check_out("t2_tmo", !TMO_EN, 1'b0, TMO_EN, 8'd0);
      bus.in_valid = 1'b0; bus.abort = 1'b1;
      cycle();
      bus.abort = 1'b0;
      check_out("t2_abort", 1'b0, 1'b0, 1'b0, 8'd0);

      // in_valid gaps carrying garbage bits
      start_run(4'b1011, 8'd5, 16'd0);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0);
      send(1, 0, 0, 0, 0); send(1, 0, 0, 0, 0); send(0, 0, 0, 0, 0);
      send(1, 1, 0, 0, 0); send(1, 1, 1, 8'd1, 0);
      idle(2);
      check_out("t3_gap", 1'b1, 1'b0, 1'b0, 8'd1);
      bus.abort = 1'b1;
      cycle();
      bus.abort = 1'b0;
      check_out("t3_abort", 1'b0, 1'b0, 1'b0, 8'd1);

      // abort coinciding with a completing match
      start_run(4'b1011, 8'd3, 16'd0);
      check_out("t4_start", 1'b1, 1'b0, 1'b0, 8'd0);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      send(1, 1, 1, 8'd1, 0);
      send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      bus.abort = 1'b1;
      send(1, 1, 0, 0, 0);
      bus.abort = 1'b0;
      check_out("t4_abort", 1'b0, 1'b0, 1'b0, 8'd1);
      idle(2);

      // abort and start together: run must not begin
      bus.pattern = 4'b1011; bus.target = 8'd1; bus.timeout = '0;
      bus.start = 1'b1; bus.abort = 1'b1;
      cycle();
      bus.start = 1'b0; bus.abort = 1'b0;
      check_out("t4_both", 1'b0, 1'b0, 1'b0, 8'd1);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      idle(1);
      check_out("t4_idle", 1'b0, 1'b0, 1'b0, 8'd1);

      // target 0 goes straight to DONE
      start_run(4'b1011, 8'd0, 16'd0);
      check_out("t5_zero", 1'b0, 1'b1, 1'b0, 8'd0);

      // start while busy is ignored
      start_run(4'b1011, 8'd2, 16'd0);
      bus.pattern = 4'b0000; bus.target = 8'd1; bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      check("t6_busy", 32'(bus.busy), 32'd1);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      send(1, 1, 1, 8'd1, 0);
      send(0, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(0, 1, 0, 0, 0);
      check_out("t6_mid", 1'b1, 1'b0, 1'b0, 8'd1);
      send(1, 1, 0, 0, 0); send(0, 1, 0, 0, 0); send(1, 1, 0, 0, 0);
      send(1, 1, 1, 8'd2, 1);
      bus.in_valid = 1'b0;

      // asynchronous reset while hit and done are high
      #2 rst_n = 1'b0;
      #1;
      check_out("arst", 1'b0, 1'b0, 1'b0, 8'd0);
      check("arst_hit", 32'(bus.hit), 32'd0);
      cycle();
      rst_n = 1'b1;
      cycle();
      check_out("arst_idle", 1'b0, 1'b0, 1'b0, 8'd0);

      check("missing_hits", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
